// File: rtl/irq_controller.sv
// irq_controller: edge-latched, masked, priority interrupt controller with a one-shot request to the control unit.
// Optional IRQ_ROUND_ROBIN_EN macro selects rotating priority instead of fixed lowest-index priority.
module irq_controller #(
    parameter int N_SRC = 4,
    parameter int ID_W = 2,
    parameter int VEC_W = 10,
    parameter logic [VEC_W-1:0] VEC_BASE = 10'h3C0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_SRC-1:0] irq_in,
    input  logic             mask_we,
    input  logic [N_SRC-1:0] mask_din,
    input  logic             s_finish_interr,
    output logic             s_interruption,
    output logic [ID_W-1:0]  irq_id,
    output logic [VEC_W-1:0] irq_vector,
    output logic [N_SRC-1:0] pending,
    output logic             busy
);
    typedef enum logic [1:0] {IDLE, REQ, SERVICE, COOL} state_t;

    state_t             state_q;
    logic [N_SRC-1:0]   irq_q;
    logic [N_SRC-1:0]   mask_q;
    logic [N_SRC-1:0]   pending_q;
    logic [N_SRC-1:0]   pending_d;
    logic               s_interruption_q;
    logic               busy_q;
    logic [ID_W-1:0]    irq_id_q;
    logic [VEC_W-1:0]   irq_vector_q;
    logic [N_SRC-1:0]   cand;
    logic [N_SRC-1:0]   clr;
    logic [ID_W-1:0]    win;

    assign cand           = pending_q & mask_q;
    assign clr            = (state_q == SERVICE && s_finish_interr) ? N_SRC'(1) << irq_id_q : '0;
    assign s_interruption = s_interruption_q;
    assign irq_id         = irq_id_q;
    assign irq_vector     = irq_vector_q;
    assign pending        = pending_q;
    assign busy           = busy_q;

`ifdef IRQ_ROUND_ROBIN_EN
    logic [ID_W-1:0] last_q;
    logic            found;
    int              idx;

    // Rotating search starting just after the last granted source.
    always_comb begin
        win   = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < N_SRC; k++) begin
            idx = (int'(last_q) + 1 + k) % N_SRC;
            if (!found && cand[idx]) begin
                win   = ID_W'(idx);
                found = 1'b1;
            end
        end
    end

    // Remember the most recent grant to rotate priority.
    always_ff @(posedge clk) begin
        if (reset)
            last_q <= ID_W'(N_SRC - 1);
        else if (state_q == IDLE && |cand)
            last_q <= win;
    end
`else
    // Fixed priority: the lowest-index candidate wins.
    always_comb begin
        win = '0;
        for (int i = N_SRC - 1; i >= 0; i--)
            if (cand[i]) win = ID_W'(i);
    end
`endif

    // New edges set pending; a simultaneous clear loses to the set.
    always_comb begin
        pending_d = (pending_q & ~clr) | (irq_in & ~irq_q);
    end

    // Edge-detect history, enable mask and pending register.
    always_ff @(posedge clk) begin
        if (reset) begin
            irq_q     <= '0;
            mask_q    <= '0;
            pending_q <= '0;
        end else begin
            irq_q     <= irq_in;
            pending_q <= pending_d;
            if (mask_we) mask_q <= mask_din;
        end
    end

    // Grant FSM with registered request pulse, busy flag and service vector.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= IDLE;
            s_interruption_q <= 1'b0;
            busy_q           <= 1'b0;
            irq_id_q         <= '0;
            irq_vector_q     <= VEC_BASE;
        end else begin
            case (state_q)
                IDLE: if (|cand) begin
                    state_q          <= REQ;
                    s_interruption_q <= 1'b1;
                    busy_q           <= 1'b1;
                    irq_id_q         <= win;
                    irq_vector_q     <= VEC_BASE + VEC_W'({win, 2'b00});
                end
                REQ: begin
                    state_q          <= SERVICE;
                    s_interruption_q <= 1'b0;
                end
                SERVICE: if (s_finish_interr) state_q <= COOL;
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: doc/irq_controller.md
# irq_controller

Interrupt controller that sits between external interrupt sources and the CPU control unit. Latches rising edges on up to `N_SRC` request lines into a pending register, applies a software-written enable mask, and arbitrates among enabled pending sources. Raises a one-cycle `s_interruption` pulse to the control unit together with a stable service vector. Blocks further grants until the control unit signals completion through `s_finish_interr` (the FNSH instruction).

## Interface
- `N_SRC`, 4: number of interrupt sources (2..16).
- `ID_W`, 2: width of `irq_id`; `2**ID_W >= N_SRC`.
- `VEC_W`, 10: program-counter width of `irq_vector`.
- `VEC_BASE`, 10'h3C0: vector of source 0.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `irq_in`  in  N_SRC  raw request lines, rising-edge sensitive.
- `mask_we`  in  1  write strobe for the enable mask.
- `mask_din`  in  N_SRC  new mask value; 1 = source enabled.
- `s_finish_interr`  in  1  end-of-service strobe from the control unit.
- `s_interruption`  out  1  interrupt request pulse to the control unit.
- `irq_id`  out  ID_W  index of the granted source.
- `irq_vector`  out  VEC_W  handler address, `VEC_BASE + 4*irq_id`, truncated to VEC_W bits.
- `pending`  out  N_SRC  pending register.
- `busy`  out  1  high from grant until return to IDLE.

## Operation
- Edge detect:
  - `irq_q` registers `irq_in`; its reset value is 0, so a line already high after reset counts as an edge.
  - An edge on source i (`irq_in[i] & ~irq_q[i]`) sets `pending[i]`, regardless of the mask.
- Mask:
  - On `mask_we`, the mask register loads `mask_din`.
  - A mask change never affects the source already in service.
  - Masked pending bits stay pending and are granted once unmasked.
- Arbitration:
  - Candidates are `pending & mask`.
  - Fixed priority: lowest index wins.
- FSM:
  - IDLE: `busy`=0. If any candidate exists, latch the winner into `irq_id`/`irq_vector` and go to REQ.
  - REQ: `s_interruption`=1 for exactly this cycle; go to SERVICE.
  - SERVICE: hold `irq_id`/`irq_vector`. When `s_finish_interr`=1, clear `pending[irq_id]` and go to COOL.
  - COOL: one cycle with no grant, so the control unit can drop its in-interrupt latch; then go to IDLE.
- No nesting: edges arriving during REQ/SERVICE/COOL only set pending bits.
- `s_finish_interr` is ignored in IDLE, REQ and COOL.
- Set-wins rule: a new edge on the serviced source in the same cycle as its clear leaves the pending bit at 1.

## Timing
- Reset values: `s_interruption`=0, `irq_id`=0, `irq_vector`=`VEC_BASE`, `pending`=0, `busy`=0, mask=0, `irq_q`=0, state IDLE.
- Reset mid-operation drops the request; the control unit is expected to be reset in the same cycle.
- Latency from a `irq_in` edge sampled at clock edge N:
  - `pending` is visible after edge N.
  - IDLE→REQ happens at edge N+1.
  - `s_interruption` is high between edges N+1 and N+2.
- `irq_id`, `irq_vector` and `busy` become valid in the same cycle as `s_interruption` and remain stable until COOL ends.
- Minimum spacing between two grants: `s_finish_interr` edge + COOL (1 cycle) + IDLE (1 cycle).
- Mask write to grant: a write at edge M makes candidates visible in IDLE after M; the next grant occurs at edge M+1.

## Configuration
- `IRQ_ROUND_ROBIN_EN`
  - Defined: rotating priority. The search starts at `(last_granted_id + 1) mod N_SRC`; `last_granted_id` resets to N_SRC-1, so source 0 is first after reset.
  - Undefined: fixed lowest-index priority; no `last_granted_id` register is instantiated.

## Test plan
- Mask=4'b1111, pulse `irq_in[2]` → `pending`=4'b0100, one-cycle `s_interruption`, `irq_id`=2, `irq_vector`=10'h3C8, `busy`=1. Then `s_finish_interr` → `pending`=0, `busy`=0 two cycles later.
- Mask=4'b1111, edges on sources 1 and 3 in the same cycle:
  - Fixed priority: grant `irq_id`=1 (10'h3C4); after finish + COOL, grant `irq_id`=3 (10'h3CC).
  - With `IRQ_ROUND_ROBIN_EN`: after servicing 1, with 0 and 3 pending, the next grant is 3.
- Mask=0, edge on source 0 → `pending`=4'b0001 and no `s_interruption`. Write mask 4'b0001 at edge M → `s_interruption` high after edge M+1.
- Source 0 in SERVICE, edge on source 2 → `pending`=4'b0101 and no second pulse. After finish + COOL, grant `irq_id`=2.
- Edge on source 1 in the same cycle as `s_finish_interr` while servicing 1 → `pending[1]` stays 1 and source 1 is granted again.
- Assert `reset` during SERVICE → next cycle: all outputs at reset values, `pending`=0, state IDLE.
